// File: rtl/fir_rc_dec.sv
// Receive-side RRC matched filter with DEC:1 decimation. One time-shared
// multiplier walks a frozen copy of the delay line once per output symbol.
module fir_rc_dec #(
    parameter int TAP_LEN = 41,
    parameter int DEC     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic [15:0]             din,
    input  logic [TAP_LEN*16-1:0]   tap,
    output logic [15:0]             dout,
    output logic                    dout_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int KW = (TAP_LEN > 1) ? $clog2(TAP_LEN) : 1;
    localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t             r_state;
    logic signed [15:0] r_sr [TAP_LEN];
    logic signed [15:0] r_fr [TAP_LEN];
    logic [PW-1:0]      r_ph;
    logic [KW-1:0]      r_k;
    logic signed [39:0] r_acc;
    logic [15:0]        r_dout;
    logic               r_dout_valid;
    logic               r_busy;
    logic               r_overrun;

    logic signed [15:0] w_sr_next [TAP_LEN];
    logic signed [15:0] w_tap [TAP_LEN];
    logic signed [31:0] w_prod;
    logic signed [39:0] w_acc_next;
    logic               w_trig;

    // Floor shift back to Q1.15 and clamp to the 16-bit output range.
    function automatic logic [15:0] sat16(input logic signed [39:0] a);
        logic signed [39:0] s;
        s = a >>> 15;
        if (s > 40'sd32767)
            sat16 = 16'h7FFF;
        else if (s < -40'sd32768)
            sat16 = 16'h8000;
        else
            sat16 = s[15:0];
    endfunction

    always_comb begin
        for (int i = 0; i < TAP_LEN; i++) begin
            w_tap[i] = tap[i*16 +: 16];
            w_sr_next[i] = (i == 0) ? $signed(din) : r_sr[(i > 0) ? i - 1 : 0];
        end
    end

    assign w_trig     = din_valid && (r_ph == PW'(DEC - 1));
    assign w_prod     = r_fr[r_k] * w_tap[r_k];
    assign w_acc_next = r_acc + {{8{w_prod[31]}}, w_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ph         <= '0;
            r_k          <= '0;
            r_acc        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < TAP_LEN; i++) begin
                r_sr[i] <= '0;
                r_fr[i] <= '0;
            end
        end else begin
            r_dout_valid <= 1'b0;

            // Sample intake runs independently of the MAC engine.
            if (din_valid) begin
                r_sr <= w_sr_next;
                r_ph <= (r_ph == PW'(DEC - 1)) ? '0 : r_ph + 1'b1;
            end

            if (w_trig && r_state != S_IDLE)
                r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_fr    <= w_sr_next;
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    // Last tap: publish the result straight from the final sum.
                    if (r_k == KW'(TAP_LEN - 1)) begin
                        r_dout       <= sat16(w_acc_next);
                        r_dout_valid <= 1'b1;
                        r_state      <= S_OUT;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_OUT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_fir_rc_dec.sv
// Directed bench for fir_rc_dec: impulse, DC gain, saturation, overrun,
// reset during MAC and single-tap pass-through.
`timescale 1ns/1ps
module tb_fir_rc_dec;

    localparam int TAP_LEN = 41;
    localparam int DEC     = 10;
    localparam int CLK_P   = 10;

    logic                  clk;
    logic                  rst;
    logic                  din_valid;
    logic [15:0]           din;
    logic [TAP_LEN*16-1:0] tap;
    logic [15:0]           dout;
    logic                  dout_valid;
    logic                  busy;
    logic                  overrun;

    int checks;
    int errors;
    int smp_idx;
    int  out_v[$];
    time out_t[$];
    time trig_t[$];

    fir_rc_dec #(.TAP_LEN(TAP_LEN), .DEC(DEC)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .tap        (tap),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #(CLK_P/2) clk = ~clk;

    always @(negedge clk) begin
        if (dout_valid) begin
            out_v.push_back(int'($signed(dout)));
            out_t.push_back($time);
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        din_valid = 1'b0;
        din = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        smp_idx = 0;
        out_v.delete();
        out_t.delete();
        trig_t.delete();
    endtask

    task automatic set_taps(input int t0, input int others, input bit ramp);
        for (int k = 0; k < TAP_LEN; k++) begin
            if (ramp)
                tap[k*16 +: 16] = 16'(k * 256);
            else if (k == 0)
                tap[k*16 +: 16] = 16'(t0);
            else
                tap[k*16 +: 16] = 16'(others);
        end
    endtask

    // One sample every 5 clocks; logs the edge that samples each trigger.
    task automatic send_sample(input int v);
        @(posedge clk);
        #1;
        din = 16'(v);
        din_valid = 1'b1;
        @(posedge clk);
        if (smp_idx % DEC == DEC - 1)
            trig_t.push_back($time);
        smp_idx++;
        #1;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_out(input string name, input int idx, input int exp);
        checks++;
        if (idx >= out_v.size()) begin
            errors++;
            $display("FAIL %s: output %0d missing (got %0d outputs), required %0d", name, idx, out_v.size(), exp);
        end else if (out_v[idx] !== exp) begin
            errors++;
            $display("FAIL %s: output %0d = %0d, required %0d", name, idx, out_v[idx], exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (dout !== 16'd0) begin errors++; $display("FAIL reset_dout: %0d, required 0", dout); end
        checks++;
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: %b, required 0", dout_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: %b, required 0", overrun); end
    endtask

    task automatic test_impulse();
        int exp_v[6] = '{2303, 4863, 7423, 9983, 0, 0};
        set_taps(0, 0, 1'b1);
        do_reset();
        for (int n = 0; n < 60; n++)
            send_sample(n == 0 ? 32767 : 0);
        repeat (50) @(posedge clk);
        checks++;
        if (out_v.size() !== 6) begin
            errors++;
            $display("FAIL impulse_count: %0d outputs, required 6", out_v.size());
        end
        for (int i = 0; i < 6; i++) begin
            check_out("impulse_value", i, exp_v[i]);
            checks++;
            if (i >= out_t.size() || i >= trig_t.size()) begin
                errors++;
                $display("FAIL impulse_timing: output %0d missing", i);
            end else if (out_t[i] + CLK_P/2 - trig_t[i] != (TAP_LEN + 1) * CLK_P) begin
                errors++;
                $display("FAIL impulse_timing: output %0d fell %0t after trigger, required %0d clocks",
                         i, out_t[i] + CLK_P/2 - trig_t[i], TAP_LEN + 1);
            end
        end
    endtask

    task automatic test_dc_gain();
        set_taps(800, 800, 1'b0);
        do_reset();
        for (int n = 0; n < 60; n++)
            send_sample(1000);
        repeat (50) @(posedge clk);
        check_out("dc_first", 0, 244);
        check_out("dc_second", 1, 488);
        check_out("dc_third", 2, 732);
        check_out("dc_fourth", 3, 976);
        check_out("dc_steady5", 4, 1000);
        check_out("dc_steady6", 5, 1000);
    endtask

    task automatic test_saturation();
        set_taps(32767, 32767, 1'b0);
        do_reset();
        for (int n = 0; n < 60; n++)
            send_sample(32767);
        repeat (50) @(posedge clk);
        check_out("sat_pos5", 4, 32767);
        check_out("sat_pos6", 5, 32767);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL sat_pos_overrun: %b, required 0", overrun); end
        do_reset();
        for (int n = 0; n < 60; n++)
            send_sample(-32768);
        repeat (50) @(posedge clk);
        check_out("sat_neg5", 4, -32768);
        check_out("sat_neg6", 5, -32768);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL sat_neg_overrun: %b, required 0", overrun); end
    endtask

    task automatic test_overrun();
        set_taps(800, 800, 1'b0);
        do_reset();
        @(posedge clk);
        #1;
        din = 16'd1000;
        din_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        din_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: %b, required 1", overrun); end
        repeat (120) @(posedge clk);
        checks++;
        if (out_v.size() !== 1) begin
            errors++;
            $display("FAIL overrun_outputs: %0d outputs, required 1", out_v.size());
        end
        check_out("overrun_value", 0, 244);
        repeat (100) @(posedge clk);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: %b, required 1", overrun); end
    endtask

    task automatic test_reset_mid_mac();
        set_taps(800, 800, 1'b0);
        do_reset();
        for (int n = 0; n < 9; n++)
            send_sample(1000);
        @(posedge clk);
        #1;
        din = 16'd1000;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        smp_idx = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmac_busy: %b, required 0", busy); end
        checks++;
        if (dout !== 16'd0) begin errors++; $display("FAIL rstmac_dout: %0d, required 0", dout); end
        repeat (60) @(posedge clk);
        checks++;
        if (out_v.size() !== 0) begin
            errors++;
            $display("FAIL rstmac_no_valid: %0d outputs, required 0", out_v.size());
        end
        for (int n = 0; n < 9; n++)
            send_sample(1000);
        repeat (50) @(posedge clk);
        checks++;
        if (out_v.size() !== 0) begin
            errors++;
            $display("FAIL rstmac_early: %0d outputs after 9 samples, required 0", out_v.size());
        end
        send_sample(1000);
        repeat (50) @(posedge clk);
        check_out("rstmac_next", 0, 244);
    endtask

    task automatic test_pass_through();
        set_taps(16384, 0, 1'b0);
        do_reset();
        for (int n = 0; n < 30; n++)
            send_sample(2 * n);
        repeat (50) @(posedge clk);
        check_out("pass_x9", 0, 9);
        check_out("pass_x19", 1, 19);
        check_out("pass_x29", 2, 29);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        smp_idx = 0;
        rst = 1'b1;
        din_valid = 1'b0;
        din = '0;
        tap = '0;
        test_reset();
        test_impulse();
        test_dc_gain();
        test_saturation();
        test_overrun();
        test_reset_mid_mac();
        test_pass_through();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_rc_dec.md
Name: fir_rc_dec

Overview:
Receive-side root-raised-cosine matched filter and decimator for the AWG sample path; the counterpart of the transmit interpolating RRC filter.
- Accepts 16-bit signed samples at sample rate (qualified by din_valid) and emits one filtered 16-bit symbol-rate output per DEC input samples.
- Uses a single time-shared multiplier. Each output is computed by a sequential TAP_LEN-cycle MAC over a snapshot of the delay line.
- Sits between the ADC/loopback sample stream and the symbol-level demodulator.

Parameters:
TAP_LEN, 41, number of filter taps (Q1.15 coefficients)
DEC, 10, decimation factor (input samples per output)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
din_valid  in  1  input sample strobe
din  in  16  signed input sample
tap  in  TAP_LEN x 16  signed coefficients, Q1.15; tap[0] applies to the newest sample; static during operation
dout  out  16  signed filtered output, holds last value
dout_valid  out  1  one-cycle pulse when dout updates
busy  out  1  MAC in progress
overrun  out  1  sticky: trigger dropped because MAC was busy

Behaviour:
- Reset state:
  - dout=0, dout_valid=0, busy=0, overrun=0.
  - Delay line sr[0..TAP_LEN-1]=0, phase counter ph=0, accumulator=0, state IDLE.
- Delay line: on each din_valid, sr <= {sr[TAP_LEN-2:0], din}; sr[0] is newest. Shifting happens regardless of FSM state.
- Phase counter: increments on each din_valid and wraps DEC-1 -> 0.
- Trigger:
  - Condition: din_valid with ph==DEC-1, i.e. the DEC-th sample since reset or since the last wrap.
  - First trigger is on input sample index DEC-1, counting from 0 after reset.
- FSM, three states:
  - IDLE: on trigger, copy the post-shift delay line (including the current din) into snapshot buffer fr[]; clear acc; k=0; go to MAC.
  - MAC: each cycle acc += fr[k]*tap[k], then k++. Runs TAP_LEN cycles (k=0..TAP_LEN-1), then goes to OUT.
  - OUT: dout <= sat16(acc >>> 15) (arithmetic shift, floor); dout_valid=1 for this cycle only; go to IDLE.
- Timing: if the trigger is sampled at edge T, MAC occupies cycles T+1..T+TAP_LEN and dout_valid is high in cycle T+TAP_LEN+1.
- busy is high from cycle T+1 through the dout_valid cycle inclusive.
- Arithmetic:
  - Products are 32-bit signed.
  - acc is 40-bit signed, so no internal overflow for TAP_LEN<=256.
  - sat16 clamps to [-32768, 32767].
- Trigger while busy (any state except IDLE):
  - Trigger is dropped and the snapshot is unchanged.
  - overrun <= 1 and stays set until rst.
  - Delay line and ph advance normally.
  - The in-flight computation completes normally.
- Rate constraint: trigger spacing must be >= TAP_LEN+2 clocks. For the defaults, at most one din_valid per 5 clocks is safe.
- rst mid-MAC: aborts immediately; no dout_valid; all state returns to reset values.
- din_valid during OUT: not a trigger (busy). If ph==DEC-1, overrun sets.

Test Plan:
- Impulse:
  - Stimulus: tap[k]=k*256; din=32767 on sample 0, then 0; din_valid every 5 clocks.
  - Required: outputs 2303, 4863, 7423, 9983, then 0, 0. Each dout_valid falls exactly TAP_LEN+1=42 clocks after its trigger edge.
- DC gain:
  - Stimulus: all tap=800; din=1000 constant.
  - Required: first output 244 (10 samples filled); 4th output 976; 5th and later outputs 1000 (steady state).
- Saturation:
  - Stimulus: all tap=32767; din=32767 constant.
  - Required: steady outputs 32767.
  - Stimulus: din=-32768 constant.
  - Required: steady outputs -32768. overrun=0 throughout.
- Overrun:
  - Stimulus: din_valid on 20 consecutive clocks.
  - Required: second trigger (sample 19) lands while busy; overrun=1 and stays 1; exactly one dout_valid; overrun still 1 after 100 idle clocks.
- Reset mid-MAC:
  - Stimulus: assert rst for 1 cycle, 10 clocks after a trigger.
  - Required: no dout_valid follows; dout=0; busy=0; next output appears only after DEC further samples.
- Pass-through:
  - Stimulus: tap[0]=16384, other taps 0; din ramp 0, 2, 4, …
  - Required: outputs x[9]/2=9, x[19]/2=19, x[29]/2=29.
